serial_bit_feeder: RTL and testbench
====================================

// Module: serial_bit_feeder
// PURPOSE
//  Parallel-to-serial front end for the bit-serial sequence detectors. Accepts
//  WIDTH-bit words on a valid/ready handshake and emits one bit per enabled
//  clock on x_out, the x input of the detector. Has a one-word holding buffer,
//  so back-to-back words stream with no idle bit between them.
// PARAMETERS
//  WIDTH      8  bits per word; legal range 2..32
//  MSB_FIRST  1  1: send in_data[WIDTH-1] first; 0: send in_data[0] first
//  IDLE_BIT   0  value driven on x_out while bit_valid=0
// PORTS
//  clk         in   1      rising-edge clock
//  reset       in   1      synchronous, active-high
//  in_data     in   WIDTH  word to serialise
//  in_valid    in   1      in_data valid
//  in_ready    out  1      block can accept a word this cycle
//  bit_en      in   1      advance enable; tie high when driving a detector directly
//  x_out       out  1      serial bit
//  bit_valid   out  1      x_out carries a data bit
//  word_start  out  1      x_out is bit 0 (first sent) of a word
//  busy        out  1      shifter or buffer holds data
// BEHAVIOUR
//  Reset: synchronous, active-high, checked on the clk rising edge; overrides
//   every other event, including a handshake in the same cycle. After reset:
//   state=IDLE, buffer empty, x_out=IDLE_BIT, bit_valid=0, word_start=0,
//   busy=0, in_ready=1. A word partly shifted out when reset arrives is dropped.
//  Storage: shift reg sh[WIDTH-1:0], remaining-bit count cnt, one buffer
//   word buf + flag buf_v.
//  FSM: IDLE (cnt=0, bit_valid=0) and SHIFT (cnt 1..WIDTH, bit_valid=1).
//  Outputs (all combinational from registers):
//   x_out = SHIFT ? (MSB_FIRST ? sh[WIDTH-1] : sh[0]) : IDLE_BIT.
//   word_start = SHIFT && cnt==WIDTH.
//   in_ready = !buf_v (never depends on in_valid).
//   busy = SHIFT || buf_v.
//  Events at each rising clk edge:
//   accept = in_valid && in_ready.
//   consume = SHIFT && bit_en. On consume with cnt>1: shift toward the output
//    end by one position, cnt-1.
//   refill = IDLE || (consume && cnt==1).
//  On refill, priority order:
//   1. buf_v: sh<=buf, cnt<=WIDTH, buf_v<=accept, buf<=in_data if accept.
//   2. else accept: sh<=in_data, cnt<=WIDTH, buffer stays empty.
//   3. else go IDLE, cnt<=0.
//  Without refill, accept writes buf and sets buf_v.
//  Latency: a word accepted into an idle, empty block shows its first bit on
//   x_out in the next cycle. A word is WIDTH consecutive enabled bits, with no
//   gap when the next word is already buffered or arrives on the last-bit edge.
//  bit_en=0 freezes sh, cnt and x_out. Input can still fill an empty buffer.
//   bit_en is ignored in IDLE, so loading does not wait for it.
//  Simultaneous: accept on last-bit edge with empty buffer loads directly into
//   the shifter. Accept on last-bit edge with full buffer cannot happen, since
//   in_ready=0.
//  Stall: in_data is ignored when in_valid=0. Upstream holds in_data while in_valid=1 && !in_ready.
//  No wrap-around state: cnt never leaves 0..WIDTH.
//  Default IDLE_BIT=0 keeps a 1010 detector in its start state while idle.
// TESTING
//  T1: WIDTH=8, MSB_FIRST=1, bit_en=1, send 8'hAA once -> x_out 1,0,1,0,1,0,1,0
//   starting one cycle after accept; word_start only on the first bit; then
//   x_out=0, bit_valid=0, busy=0. Detector chained to x_out pulses z on bits 4 and 8.
//  T2: back-to-back 8'hA5 then 8'h3C with in_valid held high -> 16 consecutive
//   valid bits 10100101 00111100; in_ready low while the buffer is full;
//   word_start on bits 1 and 9.
//  T3: MSB_FIRST=0, word 8'h01 -> first bit 1, then seven 0s.
//  T4: during 8'hF0 hold bit_en=0 for 3 cycles after bit 2 -> x_out and
//   bit_valid hold for 3 cycles; sequence resumes unchanged, 8 bits total.
//  T5: assert reset mid-word (after bit 3) with a word in the buffer -> the next
//   cycle shows bit_valid=0, busy=0, in_ready=1, x_out=IDLE_BIT; the next
//   accepted word streams from its first bit.
//  T6: random in_valid/bit_en for 10k cycles against a scoreboard -> bit stream
//   equals the accepted words in order; no word lost or duplicated.

Source files
------------

// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: parallel-to-serial front end for bit-serial sequence detectors.
//   Accepts WIDTH-bit words on in_valid/in_ready and emits one bit per enabled
//   clock on x_out. A one-word holding buffer lets consecutive words stream with
//   no idle bit between them.
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   in_data/in_valid/in_ready  word input handshake (in_ready = holding buffer empty)
//   bit_en                     advance enable for the shifter (ignored while idle)
//   x_out/bit_valid/word_start serial bit, data-bit qualifier, first-bit-of-word flag
//   busy                       shifter or holding buffer holds data
module serial_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             bit_en,
  output logic             x_out,
  output logic             bit_valid,
  output logic             word_start,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_v_q, hold_v_d;

  logic accept;
  logic consume;
  logic last_bit;
  logic refill;

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    hold_v_d = hold_v_q;

    accept   = in_valid && !hold_v_q;
    consume  = (state_q == SHIFT) && bit_en;
    last_bit = consume && (cnt_q == CW'(1));
    // The shifter reloads either when idle or on the edge that consumes its
    // last bit, which is what makes back-to-back words gapless.
    refill   = (state_q == IDLE) || last_bit;

    if (consume && !last_bit) begin
      // Move the next bit toward whichever end drives x_out.
      if (MSB_FIRST) sh_d = {sh_q[WIDTH-2:0], 1'b0};
      else           sh_d = {1'b0, sh_q[WIDTH-1:1]};
      cnt_d = cnt_q - CW'(1);
    end

    if (refill) begin
      if (hold_v_q) begin
        // Buffered word goes first; a word arriving this edge takes its place.
        sh_d     = hold_q;
        cnt_d    = CW'(WIDTH);
        state_d  = SHIFT;
        hold_v_d = accept;
        if (accept) hold_d = in_data;
      end else if (accept) begin
        // Empty buffer: bypass it and load the shifter directly.
        sh_d    = in_data;
        cnt_d   = CW'(WIDTH);
        state_d = SHIFT;
      end else begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    end else if (accept) begin
      hold_d   = in_data;
      hold_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      cnt_q    <= '0;
      hold_q   <= '0;
      hold_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
    end
  end

  assign bit_valid  = (state_q == SHIFT);
  assign x_out      = bit_valid ? (MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0]) : IDLE_BIT;
  assign word_start = bit_valid && (cnt_q == CW'(WIDTH));
  assign in_ready   = !hold_v_q;
  assign busy       = bit_valid || hold_v_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb_serial_bit_feeder: directed vector table plus scoreboarded random traffic
//   for serial_bit_feeder (WIDTH=8, MSB-first main instance, LSB-first second
//   instance).
module tb_serial_bit_feeder;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       bit_en;
  logic       x_out;
  logic       bit_valid;
  logic       word_start;
  logic       busy;

  logic [7:0] l_in_data;
  logic       l_in_valid;
  logic       l_in_ready;
  logic       l_bit_en;
  logic       l_x_out;
  logic       l_bit_valid;
  logic       l_word_start;
  logic       l_busy;

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .bit_en(bit_en), .x_out(x_out), .bit_valid(bit_valid),
    .word_start(word_start), .busy(busy)
  );

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .in_data(l_in_data), .in_valid(l_in_valid),
    .in_ready(l_in_ready), .bit_en(l_bit_en), .x_out(l_x_out), .bit_valid(l_bit_valid),
    .word_start(l_word_start), .busy(l_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      g;
    logic       rst;
    logic       vld;
    logic [7:0] dat;
    logic       en;
    logic [4:0] exp;   // {x_out, bit_valid, word_start, in_ready, busy}
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [4:0] o(logic x, logic bv, logic ws, logic rdy, logic bsy);
    return {x, bv, ws, rdy, bsy};
  endfunction

  function automatic void add(string g, logic r, logic v, logic [7:0] d, logic e, logic [4:0] x);
    vec_t t;
    t.g = g; t.rst = r; t.vld = v; t.dat = d; t.en = e; t.exp = x;
    tbl.push_back(t);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  logic [1:0] q[$];   // expected {bit, word_start} stream for random traffic
  logic [7:0] w;
  logic [15:0] s;
  logic [1:0] f;
  int         guard;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; bit_en = 1'b0;
    l_in_valid = 1'b0; l_in_data = '0; l_bit_en = 1'b0;

    // Reset state.
    add("rst", 1, 0, 8'h00, 0, o(0, 0, 0, 1, 0));

    // T1: single word 8'hAA, MSB first.
    w = 8'hAA;
    add("t1", 0, 1, w, 1, o(1, 1, 1, 1, 1));
    for (int i = 1; i < 8; i++) add("t1", 0, 0, 8'h00, 1, o(w[7-i], 1, 0, 1, 1));
    add("t1_idle", 0, 0, 8'h00, 1, o(0, 0, 0, 1, 0));

    // T2: 8'hA5 then 8'h3C back to back; second word waits in the buffer.
    s = 16'hA53C;
    for (int i = 0; i < 16; i++)
      add("t2", 0, (i < 2), (i == 0) ? 8'hA5 : 8'h3C, 1,
          o(s[15-i], 1, (i == 0 || i == 8), !(i >= 1 && i <= 7), 1));
    add("t2_idle", 0, 0, 8'h00, 1, o(0, 0, 0, 1, 0));

    // T4: 8'hF0 with bit_en low for 3 cycles after bit 2.
    w = 8'hF0;
    add("t4", 0, 1, w, 1, o(1, 1, 1, 1, 1));
    add("t4", 0, 0, 8'h00, 1, o(w[6], 1, 0, 1, 1));
    for (int i = 0; i < 3; i++) add("t4_frz", 0, 0, 8'h00, 0, o(w[6], 1, 0, 1, 1));
    for (int i = 2; i < 8; i++) add("t4", 0, 0, 8'h00, 1, o(w[7-i], 1, 0, 1, 1));
    add("t4_idle", 0, 0, 8'h00, 1, o(0, 0, 0, 1, 0));

    // T5: reset after bit 3 with a word buffered; reset beats a same-cycle handshake.
    add("t5", 0, 1, 8'hC3, 1, o(1, 1, 1, 1, 1));
    add("t5", 0, 1, 8'h5A, 1, o(1, 1, 0, 0, 1));
    add("t5", 0, 0, 8'h00, 1, o(0, 1, 0, 0, 1));
    add("t5_rst", 1, 1, 8'h77, 1, o(0, 0, 0, 1, 0));
    // Loading from idle does not wait for bit_en.
    w = 8'h96;
    add("t5_new", 0, 1, w, 0, o(1, 1, 1, 1, 1));
    for (int i = 1; i < 8; i++) add("t5_new", 0, 0, 8'h00, 1, o(w[7-i], 1, 0, 1, 1));
    add("t5_idle", 0, 0, 8'h00, 1, o(0, 0, 0, 1, 0));

    foreach (tbl[i]) begin
      @(negedge clk);
      reset = tbl[i].rst; in_valid = tbl[i].vld; in_data = tbl[i].dat; bit_en = tbl[i].en;
      @(posedge clk); #1;
      chk($sformatf("%s[%0d]", tbl[i].g, i),
          {27'd0, x_out, bit_valid, word_start, in_ready, busy}, {27'd0, tbl[i].exp});
    end

    // T3: LSB-first instance, word 8'h01 -> 1 then seven 0s.
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; bit_en = 1'b0;
    l_in_valid = 1'b1; l_in_data = 8'h01; l_bit_en = 1'b1;
    @(posedge clk); #1;
    chk("t3_first", {30'd0, l_x_out, l_word_start}, {30'd0, 1'b1, 1'b1});
    @(negedge clk);
    l_in_valid = 1'b0;
    for (int i = 1; i < 8; i++) begin
      @(posedge clk); #1;
      chk($sformatf("t3_bit%0d", i), {30'd0, l_x_out, l_bit_valid}, {30'd0, 1'b0, 1'b1});
    end
    @(posedge clk); #1;
    chk("t3_idle", {30'd0, l_bit_valid, l_busy}, 32'd0);

    // T6: random in_valid/bit_en against a bit-level scoreboard.
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      // Upstream holds a stalled word; otherwise it may present a new one.
      if (!(in_valid && !in_ready)) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_data  = 8'($urandom);
      end
      bit_en = ($urandom_range(0, 3) != 0);
      if (bit_valid && bit_en) begin
        if (q.size() == 0) begin
          chk("t6_extra_bit", {31'd0, bit_valid}, 32'd0);
        end else begin
          f = q.pop_front();
          chk($sformatf("t6_bit@%0d", c), {30'd0, x_out, word_start}, {30'd0, f});
        end
      end
      if (in_valid && in_ready)
        for (int i = 7; i >= 0; i--) q.push_back({in_data[i], (i == 7)});
    end
    @(negedge clk);
    in_valid = 1'b0; bit_en = 1'b1;
    guard = 0;
    while (busy && guard < 100) begin
      if (bit_valid) begin
        if (q.size() == 0) begin
          chk("t6_drain_extra", {31'd0, bit_valid}, 32'd0);
        end else begin
          f = q.pop_front();
          chk("t6_drain", {30'd0, x_out, word_start}, {30'd0, f});
        end
      end
      @(negedge clk);
      guard++;
    end
    chk("t6_left", q.size(), 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
